// File: rtl/lms_fifo_core.sv
// Single-clock registered-read FIFO between the sample producer and the LMS datapath.
// Define LMS_FIFO_OUTPUT_REG_EN to add an output register after the RAM read (read latency 2).
module lms_fifo_core #(
  parameter int DEPTH_WIDTH      = 10,
  parameter int DATA_WIDTH       = 16,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_en,
  output logic                   wr_full,
  output logic [DEPTH_WIDTH:0]   wr_water_level,
  output logic                   almost_full,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_en,
  output logic                   rd_empty,
  output logic [DEPTH_WIDTH:0]   rd_water_level,
  output logic                   almost_empty
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_LEVEL = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AF_LEVEL   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_LEVEL   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH:0]   wr_ptr, rd_ptr;
  logic [DEPTH_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic [DEPTH_WIDTH:0]   level;
  logic                   wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0]  ram_q;

  // Acceptance uses the registered flags only, so a read never bypasses an
  // empty FIFO and a write is never admitted into a full one.
  always_comb begin
    wr_acc     = wr_en && !wr_full && !rst;
    rd_acc     = rd_en && !rd_empty && !rst;
    wr_ptr_nxt = wr_ptr + (DEPTH_WIDTH+1)'(wr_acc);
    rd_ptr_nxt = rd_ptr + (DEPTH_WIDTH+1)'(rd_acc);
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      wr_full      <= 1'b0;
      rd_empty     <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      wr_full      <= (level_nxt == FULL_LEVEL);
      rd_empty     <= (level_nxt == '0);
      almost_full  <= (level_nxt >= AF_LEVEL);
      almost_empty <= (level_nxt <= AE_LEVEL);
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; contents
  // survive rst, only the pointers forget them.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q <= '0;
    end else if (rd_acc) begin
      ram_q <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
    end
  end

`ifdef LMS_FIFO_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= ram_q;
    end
  end

  assign rd_data = out_q;
`else
  assign rd_data = ram_q;
`endif

  assign wr_water_level = level;
  assign rd_water_level = level;

endmodule

// File: tb/tb_lms_fifo_core.sv
// Bench for lms_fifo_core: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_lms_fifo_core;

  localparam int DW = 16;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_full;
  logic [LW-1:0] wr_water_level;
  logic          almost_full;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic          rd_empty;
  logic [LW-1:0] rd_water_level;
  logic          almost_empty;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  lms_fifo_core dut (
    .clk            (clk),
    .rst            (rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_data        (rd_data),
    .rd_en          (rd_en),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words plus the read-data pipeline.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd   = '0;
  logic [DW-1:0] m_out  = '0;

  task automatic model_step();
    bit full_now, empty_now;
    full_now  = (q.size() == 1024);
    empty_now = (q.size() == 0);
    if (rst) begin
      q.delete();
      m_rd  = '0;
      m_out = '0;
    end else begin
      m_out = m_rd;
      if (rd_en && !empty_now) m_rd = q.pop_front();
      if (wr_en && !full_now) q.push_back(wr_data);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  function automatic logic [DW-1:0] model_data();
`ifdef LMS_FIFO_OUTPUT_REG_EN
    return m_out;
`else
    return m_rd;
`endif
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("wr_water_level", 32'(wr_water_level), 32'(q.size()));
      check("rd_water_level", 32'(rd_water_level), 32'(q.size()));
      check("wr_full",        32'(wr_full),        32'(q.size() == 1024));
      check("rd_empty",       32'(rd_empty),       32'(q.size() == 0));
      check("almost_full",    32'(almost_full),    32'(q.size() >= 1020));
      check("almost_empty",   32'(almost_empty),   32'(q.size() <= 4));
      check("rd_data",        32'(rd_data),        32'(model_data()));
    end
  end

  // Drives one clock of stimulus; returns just after the following falling edge.
  task automatic cycle(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    rst     = r;
    wr_en   = w;
    rd_en   = rd;
    wr_data = d;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk_en = 1'b1;

    // 1: reset state
    check("t1_level",        32'(wr_water_level), 32'd0);
    check("t1_empty",        32'(rd_empty),       32'd1);
    check("t1_almost_empty", 32'(almost_empty),   32'd1);
    check("t1_full",         32'(wr_full),        32'd0);
    check("t1_rd_data",      32'(rd_data),        32'd0);

    // 2: 1025 writes, last one dropped
    for (int i = 0; i < 1025; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'hFFFF - 16'(i));
      if (i == 1018) check("t2_af_below", 32'(almost_full), 32'd0);
      if (i == 1019) check("t2_af_at",    32'(almost_full), 32'd1);
      if (i == 1022) check("t2_full_1023", 32'(wr_full),    32'd0);
      if (i == 1023) check("t2_full_1024", 32'(wr_full),    32'd1);
    end
    check("t2_level", 32'(wr_water_level), 32'd1024);
    check("t2_full",  32'(wr_full),        32'd1);

    // 3: 1025 reads, the last one ignored
    for (int i = 0; i < 1025; i++) begin
      cycle(1'b0, 1'b0, 1'b1, '0);
`ifndef LMS_FIFO_OUTPUT_REG_EN
      if (i < 1024) check("t3_rd_data", 32'(rd_data), 32'(16'hFFFF - 16'(i)));
`endif
      if (i == 1023) check("t3_empty", 32'(rd_empty), 32'd1);
    end
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("t3_hold", 32'(rd_data), 32'h0000FC00);
    check("t3_level", 32'(rd_water_level), 32'd0);

    // 4: level 3 with simultaneous read and write held
    cycle(1'b0, 1'b1, 1'b0, 16'h000A);
    cycle(1'b0, 1'b1, 1'b0, 16'h000B);
    cycle(1'b0, 1'b1, 1'b0, 16'h000C);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 16'h0100 + 16'(k));
      check("t4_level", 32'(wr_water_level), 32'd3);
      check("t4_almost_empty", 32'(almost_empty), 32'd1);
`ifndef LMS_FIFO_OUTPUT_REG_EN
      if (k < 3) check("t4_order_head", 32'(rd_data), 32'(16'h000A + 16'(k)));
      else       check("t4_order_tail", 32'(rd_data), 32'(16'h0100 + 16'(k - 3)));
`endif
    end

    // 5: fill to 1024, then read+write: only the read is accepted
    for (int i = 0; i < 1021; i++) cycle(1'b0, 1'b1, 1'b0, 16'h2000 + 16'(i));
    check("t5_level_full", 32'(wr_water_level), 32'd1024);
    cycle(1'b0, 1'b1, 1'b1, 16'hDEAD);
    check("t5_level", 32'(wr_water_level), 32'd1023);
    check("t5_full",  32'(wr_full),        32'd0);

    // 6: reset mid-stream at level 500
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 500; i++) cycle(1'b0, 1'b1, 1'b0, 16'h3000 + 16'(i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 16'h4000 + 16'(i));
    check("t6_level_500", 32'(wr_water_level), 32'd500);
    cycle(1'b1, 1'b1, 1'b1, 16'h5555);
    check("t6_level",    32'(wr_water_level), 32'd0);
    check("t6_empty",    32'(rd_empty),       32'd1);
    check("t6_rd_data",  32'(rd_data),        32'd0);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("t6_no_read",  32'(rd_data),        32'd0);

    cycle(1'b0, 1'b0, 1'b0, '0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
